best_1ofn_busy_pipe: RTL

BEST_1OFN_BUSY_PIPE -- requirements
Module: best_1ofn_busy_pipe

---
 rtl/best_1ofn_busy_pipe_if.sv | 63 ++++++
 rtl/best_1ofn_busy_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/best_1ofn_busy_pipe_if.sv
// ---------------------------------------------------------------------------
// best_1ofn_busy_pipe_if
//   Bundles the input and result signals of best_1ofn_busy_pipe.
//   master : the block feeding candidates and consuming results
//   slave  : the selector itself
//
//   in_vld_i      strobe qualifying all channel inputs this cycle
//   pat_i         NCH packed patterns, channel c at [c*PATW +: PATW]
//   key_i         NCH packed keys
//   carry_i       NCH packed carries
//   offs_i        NCH packed offsets
//   bend_i        NCH packed bends
//   bsy_i         per-channel busy; a busy channel is never selected
//   cnt_clr_i     synchronous clear of the all-busy counter
//   out_vld_o     result valid
//   best_pat_o    winning pattern
//   best_key_o    adjusted global key
//   best_bend_o   winning bend
//   best_carry_o  winning carry
//   best_subkey_o sub-strip key
//   best_bsy_o    every channel was busy
//   bsy_cnt_o     count of valid all-busy results (saturating)
// ---------------------------------------------------------------------------
interface best_1ofn_busy_pipe_if #(
    parameter int NCH   = 7,
    parameter int PATW  = 11,
    parameter int KEYW  = 5,
    parameter int OFFSW = 4,
    parameter int BNDW  = 5,
    parameter int CARW  = 12
);
    localparam int KEYXW = KEYW + 3;

    logic                  in_vld_i;
    logic [NCH*PATW-1:0]   pat_i;
    logic [NCH*KEYW-1:0]   key_i;
    logic [NCH*CARW-1:0]   carry_i;
    logic [NCH*OFFSW-1:0]  offs_i;
    logic [NCH*BNDW-1:0]   bend_i;
    logic [NCH-1:0]        bsy_i;
    logic                  cnt_clr_i;

    logic                  out_vld_o;
    logic [PATW-1:0]       best_pat_o;
    logic [KEYXW-1:0]      best_key_o;
    logic [BNDW-1:0]       best_bend_o;
    logic [CARW-1:0]       best_carry_o;
    logic [KEYXW+1:0]      best_subkey_o;
    logic                  best_bsy_o;
    logic [15:0]           bsy_cnt_o;

    modport master (
        output in_vld_i, pat_i, key_i, carry_i, offs_i, bend_i, bsy_i, cnt_clr_i,
        input  out_vld_o, best_pat_o, best_key_o, best_bend_o, best_carry_o,
               best_subkey_o, best_bsy_o, bsy_cnt_o
    );

    modport slave (
        input  in_vld_i, pat_i, key_i, carry_i, offs_i, bend_i, bsy_i, cnt_clr_i,
        output out_vld_o, best_pat_o, best_key_o, best_bend_o, best_carry_o,
               best_subkey_o, best_bsy_o, bsy_cnt_o
    );
endinterface

// File: rtl/best_1ofn_busy_pipe.sv
// ---------------------------------------------------------------------------
// best_1ofn_busy_pipe
//   Two-stage best-of-N selector. Among the non-busy channels the one with
//   the largest sort key pat[PATW-1:1] wins, ties going to the lowest index.
//   Stage 1 registers the four pairwise winners, stage 2 resolves the final
//   winner and registers every output. Latency 2 clocks, one input per clock.
//
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  best_1ofn_busy_pipe_if.slave (see interface header for signals)
//
//   Build option: define BEST_KEY_CLAMP_EN to saturate the adjusted key
//   (below 0 -> key/subkey all zeros, above max -> key/subkey all ones).
//   Default build wraps modulo 2^KEYXW.
// ---------------------------------------------------------------------------
module best_1ofn_busy_pipe #(
    parameter int NCH   = 7,
    parameter int PATW  = 11,
    parameter int KEYW  = 5,
    parameter int OFFSW = 4,
    parameter int BNDW  = 5,
    parameter int CARW  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    best_1ofn_busy_pipe_if.slave  bus
);
    localparam int KEYXW = KEYW + 3;
    // Two guard bits: one for the +4 overshoot, one for the sign of the -2.
    localparam int SUMW  = KEYXW + 2;

    typedef struct packed {
        logic             vld;
        logic [2:0]       idx;
        logic [PATW-1:0]  pat;
        logic [KEYW-1:0]  key;
        logic [OFFSW-1:0] offs;
        logic [BNDW-1:0]  bend;
        logic [CARW-1:0]  carry;
    } cand_t;

    // Left operand is always the lower channel index, so keeping it on an
    // equal key gives the lowest-index tie break at every tree level.
    function automatic cand_t pick(input cand_t a, input cand_t b);
        if (b.vld && (!a.vld || (b.pat[PATW-1:1] > a.pat[PATW-1:1])))
            pick = b;
        else
            pick = a;
    endfunction

    // ------------------------------------------------------------ stage 1
    // Channels are padded to eight; slots at or above NCH never win.
    cand_t ch [8];

    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NCH) begin : g_real
            assign ch[g] = '{
                vld:   !bus.bsy_i[g],
                idx:   3'(g),
                pat:   bus.pat_i[g*PATW +: PATW],
                key:   bus.key_i[g*KEYW +: KEYW],
                offs:  bus.offs_i[g*OFFSW +: OFFSW],
                bend:  bus.bend_i[g*BNDW +: BNDW],
                carry: bus.carry_i[g*CARW +: CARW]
            };
        end else begin : g_pad
            assign ch[g] = '0;
        end
    end

    cand_t s1_d [4];
    cand_t s1_q [4];
    logic  s1_vld_q;

    always_comb begin
        for (int i = 0; i < 4; i++)
            s1_d[i] = pick(ch[2*i], ch[2*i+1]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            // NOTE: the pipeline array is reset too, so in-flight data is
            // flushed rather than left as stale contents.
            for (int i = 0; i < 4; i++)
                s1_q[i] <= '0;
        end else begin
            s1_vld_q <= bus.in_vld_i;
            s1_q     <= s1_d;
        end
    end

    // ------------------------------------------------------------ stage 2
    cand_t              win;
    logic [SUMW-1:0]    sum_w;
    logic [1:0]         lo2_w;
    logic [KEYXW-1:0]   key_w;
    logic [KEYXW+1:0]   sub_w;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        win   = pick(pick(s1_q[0], s1_q[1]), pick(s1_q[2], s1_q[3]));
        sum_w = {2'b00, win.idx, win.key}
              + SUMW'(win.offs[3:2])
              + SUMW'(win.offs[1] & win.offs[0])
              - SUMW'(2);
        lo2_w = win.offs[1:0] + 2'd1;
        key_w = sum_w[KEYXW-1:0];
        sub_w = {key_w, lo2_w};
`ifdef BEST_KEY_CLAMP_EN
        // Sign bit set: result went below zero. Next bit set: above max.
        if (sum_w[SUMW-1]) begin
            key_w = '0;
            sub_w = '0;
        end else if (sum_w[SUMW-2]) begin
            key_w = '1;
            sub_w = '1;
        end
`else
`endif
    end

    logic               out_vld_d,     out_vld_q;
    logic [PATW-1:0]    best_pat_d,    best_pat_q;
    logic [KEYXW-1:0]   best_key_d,    best_key_q;
    logic [BNDW-1:0]    best_bend_d,   best_bend_q;
    logic [CARW-1:0]    best_carry_d,  best_carry_q;
    logic [KEYXW+1:0]   best_subkey_d, best_subkey_q;
    logic               best_bsy_d,    best_bsy_q;
    logic [15:0]        bsy_cnt_d,     bsy_cnt_q;

    always_comb begin
        out_vld_d     = s1_vld_q;
        best_pat_d    = '0;
        best_key_d    = '0;
        best_bend_d   = '0;
        best_carry_d  = '0;
        best_subkey_d = '0;
        best_bsy_d    = 1'b0;
        if (s1_vld_q) begin
            if (win.vld) begin
                best_pat_d    = win.pat;
                best_key_d    = key_w;
                best_bend_d   = win.bend;
                best_carry_d  = win.carry;
                best_subkey_d = sub_w;
            end else begin
                best_bsy_d    = 1'b1;
            end
        end

        // Counter moves on the same edge that registers the all-busy result;
        // a clear on that edge wins.
        bsy_cnt_d = bsy_cnt_q;
        if (bus.cnt_clr_i)
            bsy_cnt_d = '0;
        else if (s1_vld_q && !win.vld && (bsy_cnt_q != 16'hFFFF))
            bsy_cnt_d = bsy_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q     <= 1'b0;
            best_pat_q    <= '0;
            best_key_q    <= '0;
            best_bend_q   <= '0;
            best_carry_q  <= '0;
            best_subkey_q <= '0;
            best_bsy_q    <= 1'b0;
            bsy_cnt_q     <= '0;
        end else begin
            out_vld_q     <= out_vld_d;
            best_pat_q    <= best_pat_d;
            best_key_q    <= best_key_d;
            best_bend_q   <= best_bend_d;
            best_carry_q  <= best_carry_d;
            best_subkey_q <= best_subkey_d;
            best_bsy_q    <= best_bsy_d;
            bsy_cnt_q     <= bsy_cnt_d;
        end
    end

    assign bus.out_vld_o     = out_vld_q;
    assign bus.best_pat_o    = best_pat_q;
    assign bus.best_key_o    = best_key_q;
    assign bus.best_bend_o   = best_bend_q;
    assign bus.best_carry_o  = best_carry_q;
    assign bus.best_subkey_o = best_subkey_q;
    assign bus.best_bsy_o    = best_bsy_q;
    assign bus.bsy_cnt_o     = bsy_cnt_q;

endmodule
